// File: rtl/readonly_cache_control_if.sv
// Wishbone handshake bundle for the read-only cache controller: the CPU-side
// slave port and the memory-side master port that the controller drives.
interface readonly_cache_control_if;
    // CPU side
    logic input_wishbone_CYC;
    logic input_wishbone_STB;
    logic input_wishbone_WE;
    logic input_wishbone_ACK;
    logic input_wishbone_ERR;
    // Memory side
    logic output_wishbone_CYC;
    logic output_wishbone_STB;
    logic output_wishbone_WE;
    logic output_wishbone_ACK;
    logic output_wishbone_RTY;

    // The controller's view: slave to the CPU, master towards memory.
    modport slave (
        input  input_wishbone_CYC,
        input  input_wishbone_STB,
        input  input_wishbone_WE,
        output input_wishbone_ACK,
        output input_wishbone_ERR,
        output output_wishbone_CYC,
        output output_wishbone_STB,
        output output_wishbone_WE,
        input  output_wishbone_ACK,
        input  output_wishbone_RTY
    );

    // The environment's view: CPU master and memory slave.
    modport master (
        output input_wishbone_CYC,
        output input_wishbone_STB,
        output input_wishbone_WE,
        input  input_wishbone_ACK,
        input  input_wishbone_ERR,
        input  output_wishbone_CYC,
        input  output_wishbone_STB,
        input  output_wishbone_WE,
        output output_wishbone_ACK,
        output output_wishbone_RTY
    );
endinterface

// File: rtl/readonly_cache_control.sv
// Sequencing FSM for the read-only cache datapath. Hits are acknowledged in
// the same cycle as the CPU strobe; misses fetch a line from memory into the
// LRU victim way and acknowledge one cycle after the memory ACK. Writes are
// rejected with ERR. Hit/miss counters saturate at all-ones.
module readonly_cache_control #(
    parameter int NUM_LINES     = 8,
    parameter int ASSOCIATIVITY = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    readonly_cache_control_if.slave          bus,
    input  logic [ASSOCIATIVITY-1:0]         hit,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] lru,
    output logic [$clog2(ASSOCIATIVITY)-1:0] cache_way_sel,
    output logic                             input_data_source_sel,
    output logic                             load,
    output logic                             load_lru,
    output logic                             input_wishbone_DAT_S_x,
    output logic [CNT_WIDTH-1:0]             hit_count,
    output logic [CNT_WIDTH-1:0]             miss_count
);
    localparam int WAY_W = $clog2(ASSOCIATIVITY);

    // The datapath shares these parameters; reject geometries it cannot build.
    generate
        if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0) begin : g_bad_lines
            $error("NUM_LINES must be a power of two >= 2");
        end
        if (ASSOCIATIVITY < 2 || (ASSOCIATIVITY & (ASSOCIATIVITY - 1)) != 0) begin : g_bad_assoc
            $error("ASSOCIATIVITY must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RETRY   = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [WAY_W-1:0]   victim_reg;
    logic [WAY_W-1:0]   hit_way;
    logic               req;
    logic               hit_inc;
    logic               miss_inc;

    assign req = bus.input_wishbone_CYC & bus.input_wishbone_STB;

    // Lowest-index set hit bit wins when several ways report a hit.
    always_comb begin
        hit_way = '0;
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
            if (hit[i]) hit_way = WAY_W'(i);
        end
    end

    // State register and victim way latched at the start of a miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            victim_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (miss_inc) victim_reg <= lru;
        end
    end

    // Next state and all handshake/datapath controls. Everything is held
    // quiet while reset is asserted so the memory cycle drops immediately.
    always_comb begin
        state_next                 = state_reg;
        bus.input_wishbone_ACK     = 1'b0;
        bus.input_wishbone_ERR     = 1'b0;
        bus.output_wishbone_CYC    = 1'b0;
        bus.output_wishbone_STB    = 1'b0;
        bus.output_wishbone_WE     = 1'b0;
        cache_way_sel              = victim_reg;
        input_data_source_sel      = 1'b0;
        load                       = 1'b0;
        load_lru                   = 1'b0;
        input_wishbone_DAT_S_x     = 1'b1;
        hit_inc                    = 1'b0;
        miss_inc                   = 1'b0;
        if (!rst) begin
            unique case (state_reg)
                IDLE: begin
                    if (req && bus.input_wishbone_WE) begin
                        bus.input_wishbone_ERR = 1'b1;
                    end else if (req && |hit) begin
                        bus.input_wishbone_ACK = 1'b1;
                        input_wishbone_DAT_S_x = 1'b0;
                        load_lru               = 1'b1;
                        cache_way_sel          = hit_way;
                        hit_inc                = 1'b1;
                    end else if (req) begin
                        miss_inc   = 1'b1;
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    bus.output_wishbone_CYC = 1'b1;
                    bus.output_wishbone_STB = 1'b1;
                    if (bus.output_wishbone_ACK) begin
                        load                  = 1'b1;
                        input_data_source_sel = 1'b1;
                        // A CPU that walked away still gets the line filled.
                        state_next = bus.input_wishbone_CYC ? RESPOND : IDLE;
                    end else if (bus.output_wishbone_RTY) begin
                        state_next = RETRY;
                    end
                end
                RETRY: begin
                    bus.output_wishbone_CYC = 1'b1;
                    state_next              = FETCH;
                end
                RESPOND: begin
                    if (req) begin
                        bus.input_wishbone_ACK = 1'b1;
                        input_wishbone_DAT_S_x = 1'b0;
                        load_lru               = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Saturating performance counters; a request bumps at most one of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && hit_count != {CNT_WIDTH{1'b1}})
                hit_count <= hit_count + 1'b1;
            if (miss_inc && miss_count != {CNT_WIDTH{1'b1}})
                miss_count <= miss_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_readonly_cache_control.sv
// Directed bench for readonly_cache_control: a table of single-cycle vectors
// for hit, miss, retry and write, then hand-written multi-cycle sequences for
// CPU abort, dropped RESPOND, reset mid-fetch and counter saturation.
module tb_readonly_cache_control;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    hit;
    logic          lru;
    logic          way_sel;
    logic          src_sel;
    logic          load;
    logic          load_lru;
    logic          dat_x;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int n_vec  = 0;
    int n_fail = 0;

    readonly_cache_control_if bus ();

    readonly_cache_control #(
        .NUM_LINES(8), .ASSOCIATIVITY(2), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .hit(hit),
        .lru(lru),
        .cache_way_sel(way_sel),
        .input_data_source_sel(src_sel),
        .load(load),
        .load_lru(load_lru),
        .input_wishbone_DAT_S_x(dat_x),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cyc, stb, we, mack, mrty;
        logic [1:0] hit;
        logic       lru;
        logic       ack, err, ocyc, ostb, ws, src, ld, ldl, x;
        logic [3:0] hc, mc;
    } vec_t;

    vec_t vec [19];

    task automatic drive(input logic cyc, input logic stb, input logic we,
                         input logic mack, input logic mrty,
                         input logic [1:0] h, input logic l);
        bus.input_wishbone_CYC  = cyc;
        bus.input_wishbone_STB  = stb;
        bus.input_wishbone_WE   = we;
        bus.output_wishbone_ACK = mack;
        bus.output_wishbone_RTY = mrty;
        hit = h;
        lru = l;
    endtask

    task automatic expect_out(input string name,
                              input logic ack, input logic err, input logic ocyc,
                              input logic ostb, input logic ws, input logic src,
                              input logic ld, input logic ldl, input logic x,
                              input logic [3:0] hc, input logic [3:0] mc);
        logic [17:0] got, exp;
        got = {bus.input_wishbone_ACK, bus.input_wishbone_ERR, bus.output_wishbone_CYC,
               bus.output_wishbone_STB, bus.output_wishbone_WE, way_sel, src_sel,
               load, load_lru, dat_x, hit_count, miss_count};
        exp = {ack, err, ocyc, ostb, 1'b0, ws, src, ld, ldl, x, hc, mc};
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ack,err,ocyc,ostb,owe,ws,src,ld,ldl,x,hc,mc=%b_%h_%h is not required %b_%h_%h",
                     name, got[17:8], got[7:4], got[3:0], exp[17:8], exp[7:4], exp[3:0]);
        end else begin
            $display("ok   %s: outputs=%b hc=%h mc=%h", name, got[17:8], got[7:4], got[3:0]);
        end
    endtask

    initial begin
        //          cyc stb we mack rty hit    lru | ack err ocyc ostb ws src ld ldl x  hc    mc
        vec[0]  = '{0, 0, 0, 0, 0, 2'b00, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0}; // idle after reset
        vec[1]  = '{1, 1, 0, 0, 0, 2'b10, 0,   1, 0, 0, 0, 1, 0, 0, 1, 0, 4'h0, 4'h0}; // hit way1
        vec[2]  = '{0, 0, 0, 0, 0, 2'b00, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h1, 4'h0}; // hit counted
        vec[3]  = '{1, 1, 0, 0, 0, 2'b11, 1,   1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h1, 4'h0}; // multi-hit -> way0
        vec[4]  = '{1, 1, 1, 0, 0, 2'b01, 0,   0, 1, 0, 0, 0, 0, 0, 0, 1, 4'h2, 4'h0}; // write -> ERR
        vec[5]  = '{0, 0, 0, 0, 0, 2'b00, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h2, 4'h0}; // counters untouched
        vec[6]  = '{1, 1, 0, 0, 0, 2'b00, 1,   0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h2, 4'h0}; // miss, victim lru=1
        vec[7]  = '{1, 1, 0, 0, 0, 2'b00, 0,   0, 0, 1, 1, 1, 0, 0, 0, 1, 4'h2, 4'h1}; // FETCH wait 1
        vec[8]  = '{1, 1, 0, 0, 0, 2'b00, 0,   0, 0, 1, 1, 1, 0, 0, 0, 1, 4'h2, 4'h1}; // FETCH wait 2
        vec[9]  = '{1, 1, 0, 1, 0, 2'b00, 0,   0, 0, 1, 1, 1, 1, 1, 0, 1, 4'h2, 4'h1}; // memory ACK -> fill
        vec[10] = '{1, 1, 0, 0, 0, 2'b00, 0,   1, 0, 0, 0, 1, 0, 0, 1, 0, 4'h2, 4'h1}; // RESPOND ACK
        vec[11] = '{0, 0, 0, 0, 0, 2'b00, 0,   0, 0, 0, 0, 1, 0, 0, 0, 1, 4'h2, 4'h1}; // back to IDLE
        vec[12] = '{1, 1, 0, 0, 0, 2'b00, 0,   0, 0, 0, 0, 1, 0, 0, 0, 1, 4'h2, 4'h1}; // miss, victim lru=0
        vec[13] = '{1, 1, 0, 0, 1, 2'b00, 0,   0, 0, 1, 1, 0, 0, 0, 0, 1, 4'h2, 4'h2}; // RTY on 1st FETCH
        vec[14] = '{1, 1, 0, 0, 0, 2'b00, 0,   0, 0, 1, 0, 0, 0, 0, 0, 1, 4'h2, 4'h2}; // RETRY: STB low
        vec[15] = '{1, 1, 0, 0, 0, 2'b00, 0,   0, 0, 1, 1, 0, 0, 0, 0, 1, 4'h2, 4'h2}; // re-issued FETCH
        vec[16] = '{1, 1, 0, 1, 1, 2'b00, 0,   0, 0, 1, 1, 0, 1, 1, 0, 1, 4'h2, 4'h2}; // ACK+RTY -> ACK wins
        vec[17] = '{1, 1, 0, 0, 0, 2'b00, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h2, 4'h2}; // RESPOND ACK
        vec[18] = '{0, 0, 0, 0, 0, 2'b00, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h2, 4'h2}; // IDLE

        // Reset with a hitting request present: everything quiet except DAT_S_x.
        rst = 1'b1;
        drive(1, 1, 0, 0, 0, 2'b01, 0);
        #2;
        expect_out("reset_outputs", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        rst = 1'b0;

        // Table: apply, let combinational outputs settle, compare, clock.
        for (int i = 0; i < 19; i++) begin
            drive(vec[i].cyc, vec[i].stb, vec[i].we, vec[i].mack, vec[i].mrty, vec[i].hit, vec[i].lru);
            #2;
            expect_out($sformatf("vec%0d", i), vec[i].ack, vec[i].err, vec[i].ocyc, vec[i].ostb,
                       vec[i].ws, vec[i].src, vec[i].ld, vec[i].ldl, vec[i].x, vec[i].hc, vec[i].mc);
            @(posedge clk);
            #1;
        end

        // CPU abort during FETCH: fill still happens, no CPU ACK afterwards.
        drive(1, 1, 0, 0, 0, 2'b00, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        #2;
        expect_out("abort_fetch", 0, 0, 1, 1, 1, 0, 0, 0, 1, 4'h2, 4'h3);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 0, 2'b00, 0);
        #2;
        expect_out("abort_fill", 0, 0, 1, 1, 1, 1, 1, 0, 1, 4'h2, 4'h3);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        #2;
        expect_out("abort_no_ack", 0, 0, 0, 0, 1, 0, 0, 0, 1, 4'h2, 4'h3);
        @(posedge clk); #1;

        // CPU drops CYC while in RESPOND: no ACK, no LRU update, then IDLE.
        drive(1, 1, 0, 0, 0, 2'b00, 0);
        @(posedge clk); #1;
        drive(1, 1, 0, 1, 0, 2'b00, 0);
        #2;
        expect_out("drop_fill", 0, 0, 1, 1, 0, 1, 1, 0, 1, 4'h2, 4'h4);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        #2;
        expect_out("respond_dropped", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h2, 4'h4);
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 0, 2'b01, 1);
        #2;
        expect_out("after_drop_hit", 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h2, 4'h4);
        @(posedge clk); #1;

        // Reset asserted mid-FETCH with a memory ACK present: no load, CYC drops at once.
        drive(1, 1, 0, 0, 0, 2'b00, 1);
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 0, 2'b00, 0);
        #2;
        expect_out("fetch_pre_rst", 0, 0, 1, 1, 1, 0, 0, 0, 1, 4'h3, 4'h5);
        drive(1, 1, 0, 1, 0, 2'b00, 0);
        rst = 1'b1;
        #1;
        expect_out("rst_mid_fetch", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        #2;
        expect_out("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0);
        @(posedge clk); #1;

        // Twenty back-to-back hits saturate the 4-bit hit counter at F.
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 0, 2'b01, 0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        #2;
        expect_out("hit_saturate", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'hF, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
